// File: rtl/sha3_pkg.sv
// Shared Keccak-f[1600] types and geometry for the theta front-end blocks.
package sha3_pkg;

    localparam int unsigned LANE_W        = 64;
    localparam int unsigned LANES_PER_ROW = 5;
    localparam int unsigned ROWS          = 5;
    localparam int unsigned STATE_LANES   = 25;
    localparam int unsigned ROW_IDX_W     = 3;
    localparam int unsigned LANE_IDX_W    = 5;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } theta_acc_state_e;

endpackage

// File: rtl/sha3_theta_terms_acc.sv
// Collects a Keccak state one plane per beat, producing the five column parities
// and the full 25-lane state with a one-cycle osample pulse for the theta-elt stage.
module sha3_theta_terms_acc
    import sha3_pkg::*;
#(
    parameter string STYLE = "basic"
) (
    input  logic                              clk,
    input  logic                              rst,
    input  lane_t [LANES_PER_ROW-1:0]         irow,
    input  logic                              ivalid,
    input  logic                              isof,
    output logic                              iready,
    output lane_t [LANES_PER_ROW-1:0]         oterm,
    output lane_t [STATE_LANES-1:0]           ostate,
    output logic                              osample,
    output logic                              oresync
);

    if (STYLE != "basic") begin : g_bad_style
        $fatal(1, "Logic style unsupported.");
    end

    theta_acc_state_e state_q, state_d;

    logic [ROW_IDX_W-1:0]          y_q, y_d;
    lane_t [LANES_PER_ROW-1:0]     par_q, par_d;
    lane_t [STATE_LANES-1:0]       st_q, st_d;
    lane_t [LANES_PER_ROW-1:0]     oterm_q, oterm_d;
    lane_t [STATE_LANES-1:0]       ostate_q, ostate_d;
    logic                          osample_q, osample_d;
    logic                          oresync_q, oresync_d;
    logic                          iready_q, iready_d;

    logic                          accept;
    logic [ROW_IDX_W-1:0]          row;
    logic                          last_row;
    logic [LANE_IDX_W-1:0]         base;
    lane_t                         par_nxt [LANES_PER_ROW];

    // isof forces the accepted beat to be plane 0 regardless of the row counter
    assign accept   = ivalid && iready_q;
    assign row      = isof ? '0 : y_q;
    assign last_row = (row == ROW_IDX_W'(ROWS - 1));

    for (genvar x = 0; x < LANES_PER_ROW; x++) begin : g_par
        assign par_nxt[x] = (row == '0) ? irow[x] : (par_q[x] ^ irow[x]);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last_row) state_d = EMIT;
            EMIT:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Datapath next-state; accept is only possible in ACCUM since iready is low in EMIT
    always_comb begin
        par_d     = par_q;
        st_d      = st_q;
        y_d       = y_q;
        oterm_d   = oterm_q;
        ostate_d  = ostate_q;
        osample_d = 1'b0;
        oresync_d = 1'b0;
        iready_d  = (state_d == ACCUM);
        base      = LANE_IDX_W'(row) * LANE_IDX_W'(LANES_PER_ROW);
        if (accept) begin
            for (int unsigned x = 0; x < LANES_PER_ROW; x++) begin
                par_d[ROW_IDX_W'(x)]             = par_nxt[ROW_IDX_W'(x)];
                st_d[base + LANE_IDX_W'(x)]      = irow[ROW_IDX_W'(x)];
            end
            oresync_d = isof && (y_q != '0);
            if (last_row) begin
                y_d       = '0;
                oterm_d   = par_d;
                ostate_d  = st_d;
                osample_d = 1'b1;
            end else begin
                y_d = row + ROW_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            par_q     <= '0;
            st_q      <= '0;
            oterm_q   <= '0;
            ostate_q  <= '0;
            osample_q <= 1'b0;
            oresync_q <= 1'b0;
            iready_q  <= 1'b1;
        end else begin
            y_q       <= y_d;
            par_q     <= par_d;
            st_q      <= st_d;
            oterm_q   <= oterm_d;
            ostate_q  <= ostate_d;
            osample_q <= osample_d;
            oresync_q <= oresync_d;
            iready_q  <= iready_d;
        end
    end

    assign iready  = iready_q;
    assign oterm   = oterm_q;
    assign ostate  = ostate_q;
    assign osample = osample_q;
    assign oresync = oresync_q;

endmodule

// File: tb/tb_sha3_theta_terms_acc.sv
// Directed bench for sha3_theta_terms_acc: pattern, all-ones/zeros, gaps, resync,
// back-to-back and mid-frame reset scenarios against hand-computed values.
module tb_sha3_theta_terms_acc;
    import sha3_pkg::*;

    typedef lane_t [LANES_PER_ROW-1:0] row_t;

    localparam lane_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                    clk = 1'b0;
    logic                    rst;
    row_t                    irow;
    logic                    ivalid;
    logic                    isof;
    logic                    iready;
    lane_t [LANES_PER_ROW-1:0] oterm;
    lane_t [STATE_LANES-1:0]   ostate;
    logic                    osample;
    logic                    oresync;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_osample = 0;
    int cyc       = 0;
    int c1        = 0;
    int n0        = 0;

    sha3_theta_terms_acc #(.STYLE("basic")) dut (
        .clk     (clk),
        .rst     (rst),
        .irow    (irow),
        .ivalid  (ivalid),
        .isof    (isof),
        .iready  (iready),
        .oterm   (oterm),
        .ostate  (ostate),
        .osample (osample),
        .oresync (oresync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (osample) n_osample++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic row_t pat_row(input int y);
        row_t r;
        for (int x = 0; x < 5; x++) r[x] = 64'h1 << (5 * y + x);
        return r;
    endfunction

    function automatic row_t const_row(input lane_t v);
        row_t r;
        for (int x = 0; x < 5; x++) r[x] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input row_t r, input logic sof);
        irow   = r;
        ivalid = 1'b1;
        isof   = sof;
        step();
        ivalid = 1'b0;
        isof   = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        ivalid = 1'b0;
        isof   = 1'b0;
        irow   = '0;
        repeat (2) step();
        check("rst_iready", 64'(iready), 64'd1);
        check("rst_osample", 64'(osample), 64'd0);
        check("rst_oresync", 64'(oresync), 64'd0);
        check("rst_oterm0", oterm[0], 64'h0);
        check("rst_ostate7", ostate[7], 64'h0);
        rst = 1'b0;
        step();

        // pattern frame
        for (int y = 0; y < 4; y++) begin
            beat(pat_row(y), y == 0);
            check("pat_no_osample", 64'(osample), 64'd0);
        end
        beat(pat_row(4), 1'b0);
        check("pat_osample", 64'(osample), 64'd1);
        check("pat_iready_emit", 64'(iready), 64'd0);
        check("pat_oterm0", oterm[0], 64'h108421);
        check("pat_oterm1", oterm[1], 64'h210842);
        check("pat_oterm4", oterm[4], 64'h1084210);
        check("pat_ostate7", ostate[7], 64'h80);
        check("pat_ostate24", ostate[24], 64'h100_0000);
        step();
        check("pat_osample_pulse", 64'(osample), 64'd0);
        check("pat_iready_back", 64'(iready), 64'd1);
        check("pat_oterm_hold", oterm[0], 64'h108421);

        // all ones then all zeros
        for (int y = 0; y < 5; y++) beat(const_row(ONES), y == 0);
        check("ones_osample", 64'(osample), 64'd1);
        check("ones_oterm2", oterm[2], ONES);
        check("ones_oterm3", oterm[3], ONES);
        step();
        for (int y = 0; y < 5; y++) beat(const_row(64'h0), y == 0);
        check("zero_osample", 64'(osample), 64'd1);
        check("zero_oterm0", oterm[0], 64'h0);
        check("zero_oterm4", oterm[4], 64'h0);
        step();

        // gapped pattern frame
        for (int y = 0; y < 5; y++) begin
            beat(pat_row(y), y == 0);
            if (y < 4) begin
                check("gap_beat_no_osample", 64'(osample), 64'd0);
                repeat (2) begin
                    step();
                    check("gap_idle_no_osample", 64'(osample), 64'd0);
                end
            end
        end
        check("gap_osample", 64'(osample), 64'd1);
        check("gap_oterm1", oterm[1], 64'h210842);
        check("gap_oterm4", oterm[4], 64'h1084210);
        step();

        // resync: partial ones frame abandoned for a pattern frame
        n0 = n_osample;
        for (int y = 0; y < 3; y++) beat(const_row(ONES), y == 0);
        check("resync_pre_oresync", 64'(oresync), 64'd0);
        beat(pat_row(0), 1'b1);
        check("resync_pulse", 64'(oresync), 64'd1);
        for (int y = 1; y < 5; y++) begin
            beat(pat_row(y), 1'b0);
            if (y == 1) check("resync_pulse_end", 64'(oresync), 64'd0);
            if (y < 4)  check("resync_no_osample", 64'(osample), 64'd0);
        end
        check("resync_osample", 64'(osample), 64'd1);
        check("resync_oterm0", oterm[0], 64'h108421);
        check("resync_ostate3", ostate[3], 64'h8);
        step();
        check("resync_one_osample", 64'(n_osample - n0), 64'd1);

        // back-to-back with ivalid held high
        ivalid = 1'b1;
        for (int y = 0; y < 5; y++) begin
            irow = pat_row(y);
            isof = (y == 0);
            step();
        end
        check("b2b_first_osample", 64'(osample), 64'd1);
        c1   = cyc;
        irow = const_row(ONES);
        isof = 1'b1;
        step();
        check("b2b_emit_osample", 64'(osample), 64'd0);
        check("b2b_emit_oresync", 64'(oresync), 64'd0);
        check("b2b_iready", 64'(iready), 64'd1);
        for (int y = 0; y < 5; y++) begin
            step();
            isof = 1'b0;
            if (y < 4) begin
                check("b2b_no_osample", 64'(osample), 64'd0);
                check("b2b_oterm_stable", oterm[4], 64'h1084210);
            end
        end
        ivalid = 1'b0;
        check("b2b_second_osample", 64'(osample), 64'd1);
        check("b2b_spacing", 64'(cyc - c1), 64'd6);
        check("b2b_oterm0", oterm[0], ONES);
        step();

        // reset after beat 2, then a full frame
        n0 = n_osample;
        for (int y = 0; y < 3; y++) beat(pat_row(y), y == 0);
        rst = 1'b1;
        step();
        check("mrst_oterm0", oterm[0], 64'h0);
        check("mrst_ostate0", ostate[0], 64'h0);
        check("mrst_osample", 64'(osample), 64'd0);
        check("mrst_iready", 64'(iready), 64'd1);
        rst = 1'b0;
        step();
        for (int y = 0; y < 5; y++) begin
            beat(const_row(ONES), y == 0);
            if (y < 4) check("mrst_no_osample", 64'(osample), 64'd0);
        end
        check("mrst_osample_final", 64'(osample), 64'd1);
        check("mrst_oterm3", oterm[3], ONES);
        check("mrst_ostate24", ostate[24], ONES);
        step();
        check("mrst_osample_count", 64'(n_osample - n0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
